// File: rtl/ofm_writeback_pkg.sv
// rtl/ofm_writeback_pkg.sv - shared constants, FSM state type and frame-length helper for ofm_writeback
package ofm_wb_pkg;

  localparam int NUM_PE         = 16;
  localparam int WORDS_PER_SET  = 4;
  localparam int LANES_PER_WORD = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } wb_state_t;

  // Words written per frame: every output pixel carries OFM_C bytes, four bytes per word.
  function automatic int unsigned calc_total_words(input int unsigned pixels, input int unsigned chans);
    return (pixels * chans) / LANES_PER_WORD;
  endfunction

endpackage

// File: rtl/ofm_writeback_if.sv
// rtl/ofm_writeback_if.sv - OFM BRAM write port bundle (master drives, slave receives)
interface ofm_writeback_if #(
  parameter int ADDR_W = 32
);

  logic              ofm_we;
  logic [ADDR_W-1:0] ofm_addr;
  logic [31:0]       ofm_data;

  modport master (output ofm_we, ofm_addr, ofm_data);
  modport slave  (input  ofm_we, ofm_addr, ofm_data);

endinterface

// File: rtl/ofm_writeback_pack_buffer.sv
// rtl/ofm_writeback_pack_buffer.sv - hold/drain lane buffers, overrun detection and word mux
// OFM_WB_RELU_EN: when defined, negative lane bytes are zeroed at hold capture.
module ofm_pack_buffer
  import ofm_wb_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   run,
  input  logic                   xfer_en,
  input  logic [NUM_PE-1:0]      lane_mask,
  input  logic [NUM_PE-1:0]      valid,
  input  logic [NUM_PE-1:0][7:0] lane_byte,
  output logic                   word_we,
  output logic [31:0]            word_data,
  output logic                   xfer,
  output logic                   overflow
);

  logic [NUM_PE-1:0][7:0] hold_q;
  logic [NUM_PE-1:0][7:0] drain_q;
  logic [NUM_PE-1:0][7:0] hold_masked;
  logic [NUM_PE-1:0][7:0] cap_byte;
  logic [NUM_PE-1:0]      filled_q;
  logic [NUM_PE-1:0]      overrun;
  logic [1:0]             widx_q;
  logic [1:0]             rem_q;
  logic                   set_done;
  logic                   drain_empty;

  function automatic logic [31:0] pick_word(input logic [NUM_PE-1:0][7:0] set, input logic [1:0] idx);
    logic [NUM_PE*8-1:0] flat;
    flat = set;
    return flat[{idx, 5'b0} +: 32];
  endfunction

  always_comb begin
    cap_byte    = '0;
    hold_masked = '0;
    for (int i = 0; i < NUM_PE; i++) begin
`ifdef OFM_WB_RELU_EN
      cap_byte[i] = lane_byte[i][7] ? 8'h00 : lane_byte[i];
`else
      cap_byte[i] = lane_byte[i];
`endif
      hold_masked[i] = lane_mask[i] ? hold_q[i] : 8'h00;
    end
  end

  // An empty mask must never complete, otherwise filled == mask would hold trivially.
  assign set_done    = (lane_mask != '0) && (filled_q == lane_mask);
  assign drain_empty = (rem_q == 2'd0);
  assign xfer        = run && xfer_en && set_done && drain_empty;
  assign overrun     = run ? (valid & lane_mask & filled_q & {NUM_PE{~xfer}}) : '0;

  // Word 0 is taken straight from hold so the first write lands on the transfer edge.
  always_comb begin
    word_we   = 1'b0;
    word_data = '0;
    if (xfer) begin
      word_we   = 1'b1;
      word_data = pick_word(hold_masked, 2'd0);
    end else if (!drain_empty) begin
      word_we   = 1'b1;
      word_data = pick_word(drain_q, widx_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hold_q   <= '0;
      drain_q  <= '0;
      filled_q <= '0;
      widx_q   <= '0;
      rem_q    <= '0;
      overflow <= 1'b0;
    end else begin
      if (xfer) begin
        drain_q <= hold_masked;
        rem_q   <= 2'd3;
        widx_q  <= 2'd1;
      end else if (!drain_empty) begin
        rem_q  <= rem_q - 2'd1;
        widx_q <= widx_q + 2'd1;
      end
      for (int i = 0; i < NUM_PE; i++) begin
        if (run && valid[i] && lane_mask[i] && (!filled_q[i] || xfer)) begin
          hold_q[i]   <= cap_byte[i];
          filled_q[i] <= 1'b1;
        end else if (xfer) begin
          filled_q[i] <= 1'b0;
        end
      end
      if (|overrun) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ofm_writeback.sv
// rtl/ofm_writeback.sv - collects 16-lane PE results into sets and writes packed words to OFM BRAM
// OFM_WB_RELU_EN: when defined, negative lane bytes are written as zero.
module ofm_writeback
  import ofm_wb_pkg::wb_state_t;
  import ofm_wb_pkg::S_IDLE;
  import ofm_wb_pkg::S_RUN;
  import ofm_wb_pkg::WORDS_PER_SET;
  import ofm_wb_pkg::calc_total_words;
#(
  parameter int NUM_PE     = 16,
  parameter int OFM_PIXELS = 2916,
  parameter int OFM_C      = 32,
  parameter int ADDR_W     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [NUM_PE-1:0]      lane_mask,
  input  logic [NUM_PE-1:0]      valid,
  input  logic [7:0]             OFM_0,
  input  logic [7:0]             OFM_1,
  input  logic [7:0]             OFM_2,
  input  logic [7:0]             OFM_3,
  input  logic [7:0]             OFM_4,
  input  logic [7:0]             OFM_5,
  input  logic [7:0]             OFM_6,
  input  logic [7:0]             OFM_7,
  input  logic [7:0]             OFM_8,
  input  logic [7:0]             OFM_9,
  input  logic [7:0]             OFM_10,
  input  logic [7:0]             OFM_11,
  input  logic [7:0]             OFM_12,
  input  logic [7:0]             OFM_13,
  input  logic [7:0]             OFM_14,
  input  logic [7:0]             OFM_15,
  ofm_writeback_if.master        bram,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam int unsigned TOTAL = calc_total_words(OFM_PIXELS, OFM_C);
  localparam int unsigned SETS  = TOTAL / WORDS_PER_SET;

  wb_state_t              state_q, state_d;
  logic                   start_acc;
  logic                   run;
  logic                   last_done;
  logic [ADDR_W-1:0]      base_q;
  logic [NUM_PE-1:0]      mask_q;
  logic [31:0]            word_cnt_q;
  logic [31:0]            set_cnt_q;
  logic                   we_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [31:0]            data_q;
  logic                   done_q;
  logic                   word_we;
  logic [31:0]            word_data;
  logic                   xfer;
  logic [NUM_PE-1:0][7:0] lane_byte;

  assign lane_byte = {OFM_15, OFM_14, OFM_13, OFM_12, OFM_11, OFM_10, OFM_9, OFM_8,
                      OFM_7,  OFM_6,  OFM_5,  OFM_4,  OFM_3,  OFM_2,  OFM_1, OFM_0};

  // The final word is on the bus this cycle; leave RUN on the next edge.
  assign last_done = (state_q == S_RUN) && we_q && (word_cnt_q == TOTAL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)     state_d = S_RUN;
      S_RUN:   if (last_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    start_acc = 1'b0;
    run       = 1'b0;
    case (state_q)
      S_IDLE:  start_acc = start;
      S_RUN:   run       = 1'b1;
      default: run       = 1'b0;
    endcase
  end

  ofm_pack_buffer u_pack (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_acc),
    .run       (run),
    .xfer_en   (set_cnt_q != SETS),
    .lane_mask (mask_q),
    .valid     (valid),
    .lane_byte (lane_byte),
    .word_we   (word_we),
    .word_data (word_data),
    .xfer      (xfer),
    .overflow  (overflow)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q     <= '0;
      mask_q     <= '0;
      word_cnt_q <= '0;
      set_cnt_q  <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= last_done;
      we_q   <= word_we;
      if (start_acc) begin
        base_q     <= base_addr;
        mask_q     <= lane_mask;
        word_cnt_q <= '0;
        set_cnt_q  <= '0;
      end else begin
        if (word_we) begin
          data_q     <= word_data;
          addr_q     <= base_q + ADDR_W'(word_cnt_q);
          word_cnt_q <= word_cnt_q + 32'd1;
        end
        if (xfer) begin
          set_cnt_q <= set_cnt_q + 32'd1;
        end
      end
    end
  end

  assign bram.ofm_we   = we_q;
  assign bram.ofm_addr = addr_q;
  assign bram.ofm_data = data_q;
  assign busy          = (state_q == S_RUN);
  assign done          = done_q;

endmodule

// File: tb/tb_ofm_writeback.sv
// tb/tb_ofm_writeback.sv - directed self-checking bench for ofm_writeback (2-pixel, 16-channel frames)
module tb_ofm_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] lane_mask;
  logic [15:0] valid;
  logic [7:0]  ofm [16];
  logic        busy;
  logic        done;
  logic        overflow;
  int          n_cmp = 0;
  int          n_bad = 0;

  ofm_writeback_if #(.ADDR_W(32)) bram ();

  ofm_writeback #(
    .NUM_PE     (16),
    .OFM_PIXELS (2),
    .OFM_C      (16),
    .ADDR_W     (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .lane_mask (lane_mask),
    .valid     (valid),
    .OFM_0     (ofm[0]),
    .OFM_1     (ofm[1]),
    .OFM_2     (ofm[2]),
    .OFM_3     (ofm[3]),
    .OFM_4     (ofm[4]),
    .OFM_5     (ofm[5]),
    .OFM_6     (ofm[6]),
    .OFM_7     (ofm[7]),
    .OFM_8     (ofm[8]),
    .OFM_9     (ofm[9]),
    .OFM_10    (ofm[10]),
    .OFM_11    (ofm[11]),
    .OFM_12    (ofm[12]),
    .OFM_13    (ofm[13]),
    .OFM_14    (ofm[14]),
    .OFM_15    (ofm[15]),
    .bram      (bram),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [31:0] a, input logic [31:0] d);
    chk({tag, ".we"},   {31'd0, bram.ofm_we}, 32'd1);
    chk({tag, ".addr"}, bram.ofm_addr, a);
    chk({tag, ".data"}, bram.ofm_data, d);
  endtask

  task automatic drive_set(input logic [15:0] v, input logic [7:0] b0);
    valid = v;
    for (int i = 0; i < 16; i++) ofm[i] = b0 + 8'(i);
  endtask

  task automatic begin_frame(input logic [31:0] base, input logic [15:0] mask);
    start     = 1'b1;
    base_addr = base;
    lane_mask = mask;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    lane_mask = '0;
    drive_set(16'h0000, 8'h00);
    tick();
    tick();
    chk("rst.we",       {31'd0, bram.ofm_we}, 32'd0);
    chk("rst.addr",     bram.ofm_addr, 32'd0);
    chk("rst.data",     bram.ofm_data, 32'd0);
    chk("rst.busy",     {31'd0, busy}, 32'd0);
    chk("rst.done",     {31'd0, done}, 32'd0);
    chk("rst.overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    tick();

    // Full frame of two sets, second set arriving while the first drains.
    begin_frame(32'h100, 16'hFFFF);
    chk("a.busy_rise", {31'd0, busy}, 32'd1);
    drive_set(16'hFFFF, 8'h00);
    tick();
    valid = '0;
    chk("a.lat_we", {31'd0, bram.ofm_we}, 32'd0);
    tick();
    chk_wr("a.w0", 32'h100, 32'h03020100);
    drive_set(16'hFFFF, 8'h10);
    tick();
    valid = '0;
    chk_wr("a.w1", 32'h101, 32'h07060504);
    tick();
    chk_wr("a.w2", 32'h102, 32'h0B0A0908);
    tick();
    chk_wr("a.w3", 32'h103, 32'h0F0E0D0C);
    tick();
    chk_wr("a.w4", 32'h104, 32'h13121110);
    tick();
    chk_wr("a.w5", 32'h105, 32'h17161514);
    tick();
    chk_wr("a.w6", 32'h106, 32'h1B1A1918);
    tick();
    chk_wr("a.w7", 32'h107, 32'h1F1E1D1C);
    chk("a.done_early", {31'd0, done}, 32'd0);
    chk("a.busy_hold",  {31'd0, busy}, 32'd1);
    tick();
    chk("a.we_end", {31'd0, bram.ofm_we}, 32'd0);
    chk("a.done",   {31'd0, done}, 32'd1);
    chk("a.busy_fall", {31'd0, busy}, 32'd0);
    tick();
    chk("a.done_pulse", {31'd0, done}, 32'd0);
    drive_set(16'hFFFF, 8'h20);
    tick();
    valid = '0;
    tick();
    tick();
    chk("a.idle_we",   {31'd0, bram.ofm_we}, 32'd0);
    chk("a.idle_busy", {31'd0, busy}, 32'd0);

    // Staggered strobes with mask 0x00FF: lane 7 completes, upper lanes ignored.
    begin_frame(32'h200, 16'h00FF);
    for (int k = 0; k < 8; k++) begin
      valid = 16'(1) << k;
      ofm[k] = 8'hA0 + 8'(k);
      tick();
    end
    valid = 16'h0100;
    ofm[8] = 8'hA8;
    tick();
    chk_wr("b.w0", 32'h200, 32'hA3A2A1A0);
    valid = 16'h0200;
    tick();
    chk_wr("b.w1", 32'h201, 32'hA7A6A5A4);
    valid = 16'h0400;
    tick();
    chk_wr("b.w2", 32'h202, 32'h00000000);
    valid = 16'h0800;
    tick();
    chk_wr("b.w3", 32'h203, 32'h00000000);
    for (int k = 12; k < 16; k++) begin
      valid = 16'(1) << k;
      tick();
    end
    valid = '0;
    chk("b.quiet_we",  {31'd0, bram.ofm_we}, 32'd0);
    chk("b.no_ovf",    {31'd0, overflow}, 32'd0);
    drive_set(16'hFFFF, 8'h30);
    tick();
    valid = '0;
    tick();
    chk_wr("b.w4", 32'h204, 32'h33323130);
    tick();
    chk_wr("b.w5", 32'h205, 32'h37363534);
    tick();
    tick();
    chk_wr("b.w7", 32'h207, 32'h00000000);
    tick();
    chk("b.done", {31'd0, done}, 32'd1);

    // Lane 3 strobes twice before completion: first byte kept, flag sticky until start.
    tick();
    begin_frame(32'h300, 16'hFFFF);
    valid = 16'h0008;
    ofm[3] = 8'h55;
    tick();
    ofm[3] = 8'h66;
    tick();
    valid = '0;
    chk("c.ovf_set", {31'd0, overflow}, 32'd1);
    drive_set(16'hFFF7, 8'h00);
    tick();
    valid = '0;
    tick();
    chk_wr("c.w0_first_kept", 32'h300, 32'h55020100);
    drive_set(16'hFFFF, 8'h00);
    tick();
    valid = '0;
    tick();
    tick();
    tick();
    chk_wr("c.w4", 32'h304, 32'h03020100);
    tick();
    tick();
    tick();
    tick();
    chk("c.done",       {31'd0, done}, 32'd1);
    chk("c.ovf_sticky", {31'd0, overflow}, 32'd1);
    tick();

    // Reset during drain word 2, then a fresh frame restarts at base.
    begin_frame(32'h400, 16'hFFFF);
    chk("d.ovf_clr_start", {31'd0, overflow}, 32'd0);
    drive_set(16'hFFFF, 8'h40);
    tick();
    valid = '0;
    tick();
    chk_wr("d.w0", 32'h400, 32'h43424140);
    tick();
    tick();
    chk_wr("d.w2", 32'h402, 32'h4B4A4948);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("d.rst_we",   {31'd0, bram.ofm_we}, 32'd0);
    chk("d.rst_addr", bram.ofm_addr, 32'd0);
    chk("d.rst_data", bram.ofm_data, 32'd0);
    chk("d.rst_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("d.no_more_we", {31'd0, bram.ofm_we}, 32'd0);
    begin_frame(32'h400, 16'hFFFF);
    drive_set(16'hFFFF, 8'h50);
    tick();
    valid = '0;
    tick();
    chk_wr("d.restart_w0", 32'h400, 32'h53525150);

    // Sign handling: 0x80 and 0xFF are negative, 0x7F and 0x01 are not.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    begin_frame(32'h500, 16'hFFFF);
    drive_set(16'hFFFF, 8'h01);
    ofm[0] = 8'h80;
    ofm[1] = 8'h7F;
    ofm[2] = 8'hFF;
    ofm[3] = 8'h01;
    tick();
    valid = '0;
    tick();
`ifdef OFM_WB_RELU_EN
    chk_wr("e.relu_w0", 32'h500, 32'h01007F00);
`else
    chk_wr("e.pass_w0", 32'h500, 32'h01FF7F80);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ofm_writeback.md
# ofm_writeback

Downstream stage of the convolution sub-top. Collects the sixteen 8-bit per-PE results (OFM_0..OFM_15, qualified by the cluster's per-PE `valid`) into a complete 16-channel set. Packs each set into four 32-bit words and writes them, in arrival order, into the OFM BRAM at consecutive addresses from a base. Double-buffers one set so the PE cluster never stalls while a previous set drains.

## Interface
Parameters:
- `NUM_PE`, 16, lanes per set (fixed to 16; 4 words per set)
- `OFM_PIXELS`, 2916, output pixels per frame (54×54)
- `OFM_C`, 32, output channels; multiple of 16
- `ADDR_W`, 32, OFM BRAM address width

Ports:
- `clk`  input  1  sole clock, rising edge
- `reset`  input  1  synchronous, active-high; clears all state
- `start`  input  1  one-cycle pulse; begins a frame (honoured in IDLE only)
- `base_addr`  input  ADDR_W  first OFM word address, sampled on `start`
- `lane_mask`  input  16  enabled lanes (driven from PE_en); sampled on `start`
- `valid`  input  16  per-lane result strobe from PE cluster
- `OFM_0`..`OFM_15`  input  8 each  per-lane result bytes
- `ofm_we`  output  1  OFM BRAM write enable
- `ofm_addr`  output  ADDR_W  OFM BRAM write address
- `ofm_data`  output  32  packed word
- `busy`  output  1  high in RUN
- `done`  output  1  one-cycle pulse after last frame word written
- `overflow`  output  1  sticky lane-overrun flag

## Operation
- FSM states: IDLE → RUN on `start`; RUN → IDLE after the final word write, with `done` pulsed. `start` in RUN is ignored.
- Frame length: TOTAL = OFM_PIXELS × OFM_C / 4 words (default 23328). Sets per frame = OFM_PIXELS × OFM_C / 16.
- Hold buffer: on `valid[i]` in RUN with `lane_mask[i]` = 1, register `OFM_i` and set `filled[i]`. Masked lanes are never awaited and pack as 0x00. `valid` is ignored in IDLE.
- Set complete when `filled` equals `lane_mask`. If the drain buffer is empty, transfer hold → drain and clear `filled` on the next edge.
- If a lane strobes in the same edge as transfer, its new byte starts the next set; this is legal.
- Overrun: `valid[i]` while `filled[i]` = 1 and no transfer on that edge → byte dropped, `overflow` set. `overflow` clears only on `reset` or `start`.
- Drain: writes word w = 0..3 on consecutive cycles. `ofm_data` = {lane 4w+3, 4w+2, 4w+1, 4w}, with lane 4w in bits [7:0].
- Addressing: `ofm_addr` = base_addr + word_cnt. `word_cnt` increments per write, is 0 at `start`, and does not wrap within a frame.
- `lane_mask` = 0: no set ever completes; the frame never finishes (the controller's responsibility).
- Reset mid-frame: all buffers, counters and flags cleared. In-flight data is discarded and nothing further is written.

## Timing
- Reset values: `ofm_we`=0, `ofm_addr`=0, `ofm_data`=0, `busy`=0, `done`=0, `overflow`=0. State is IDLE.
- `busy` rises in the cycle after the `start` edge.
- Latency: completing `valid` sampled at edge E0 → transfer at E1 → `ofm_we` high in the 4 cycles following E1. All outputs are registered.
- Drain needs 4 cycles per set. Sets arriving faster than one per 4 cycles accumulate in hold and overrun only when a lane repeats.
- `done` is high in the cycle after the last `ofm_we`, coincident with `busy` falling.

## Configuration
- `OFM_WB_RELU_EN` defined: each lane byte is treated as signed int8. A negative value (bit 7 = 1) is replaced with 0x00 at hold capture.
- Macro undefined: bytes pass through unmodified.

## Structure
- Package `ofm_wb_pkg`: `NUM_PE`, `WORDS_PER_SET` (= 4), FSM state enum typedef, and the function computing TOTAL from OFM_PIXELS/OFM_C.
- Sub-module `ofm_pack_buffer`: hold + drain registers, filled flags, overrun detection, and word mux.
- Top handles the FSM, address/word counter, and done.

## Test plan
- All 16 lanes strobe together with bytes 0x00..0x0F, base 0x100 → writes 0x03020100@0x100, 0x07060504@0x101, 0x0B0A0908@0x102, 0x0F0E0D0C@0x103, starting 2 cycles after the strobe.
- Lanes strobe staggered one per cycle, mask 0x00FF → set completes on lane 7. Words 2..3 are 0x00000000 and lanes 8..15 are ignored.
- OFM_PIXELS=2, OFM_C=16, back-to-back sets → 8 writes at base..base+7, `done` pulses once after the 8th, `busy` falls, and later `valid` is ignored.
- Lane 3 strobes twice before the set completes → `overflow`=1, first byte kept. The flag persists until the next `start` clears it.
- Reset asserted during drain word 2 → no further `ofm_we`, all outputs zero next cycle. A fresh `start` writes from `base_addr` again.
- With `OFM_WB_RELU_EN`, lane bytes 0x80 and 0x7F → packed as 0x00 and 0x7F. Without the macro → 0x80 and 0x7F.
